// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter.
// Address width, data width and requester indices.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with one-hot grant.
// The requester not granted last wins a contention.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 1 when the load port holds priority for the next contention
    logic favour_load;

    // grant the sole requester, or the favoured one on contention
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (req == 2'b11) begin
                if (favour_load) begin
                    grant[REQ_LOAD] = 1'b1;
                end else begin
                    grant[REQ_ALU] = 1'b1;
                end
            end else begin
                grant = req;
            end
        end
    end

    // pointer moves away from whoever was just granted
    always_ff @(posedge clk) begin
        if (reset) begin
            favour_load <= 1'b0;
        end else if (grant[REQ_ALU]) begin
            favour_load <= 1'b1;
        end else if (grant[REQ_LOAD]) begin
            favour_load <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file
// write port and tracks pending destinations in a scoreboard.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0]     req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  req1_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_reg,
    output logic                  rf_write_switch,
    output logic [REG_ADDR_W-1:0] rf_write_register,
    output logic [DATA_W-1:0]     rf_write_data,
    output logic [NUM_REGS-1:0]   busy_mask
);

    logic [1:0]            grant;
    logic                  accept;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0]     sel_data;
    logic [NUM_REGS-1:0]   busy_next;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[REQ_ALU];
    assign req1_ready = grant[REQ_LOAD];
    assign accept     = |grant;

    // route the granted request; r0 writes are consumed silently
    always_comb begin
        sel_reg  = req0_reg;
        sel_data = req0_data;
        if (grant[REQ_LOAD]) begin
            sel_reg  = req1_reg;
            sel_data = req1_data;
        end
        wr_en = accept && (sel_reg != '0);
    end

    // output stage: one-cycle write pulse, address/data held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_switch   <= 1'b0;
            rf_write_register <= '0;
            rf_write_data     <= '0;
        end else begin
            rf_write_switch <= wr_en;
            if (wr_en) begin
                rf_write_register <= sel_reg;
                rf_write_data     <= sel_data;
            end
        end
    end

    // scoreboard update: clear on commit, then set on issue so set wins
    always_comb begin
        busy_next = busy_mask;
        if (wr_en) begin
            busy_next[sel_reg] = 1'b0;
        end
        if (issue_valid && (issue_reg != '0)) begin
            busy_next[issue_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // scoreboard register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
// Expected values are hand-computed per vector.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [4:0]  req0_reg;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_reg;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        rf_write_switch;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic [31:0] busy_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_W   (32),
        .NUM_REGS (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req0_valid        (req0_valid),
        .req0_reg          (req0_reg),
        .req0_data         (req0_data),
        .req0_ready        (req0_ready),
        .req1_valid        (req1_valid),
        .req1_reg          (req1_reg),
        .req1_data         (req1_data),
        .req1_ready        (req1_ready),
        .issue_valid       (issue_valid),
        .issue_reg         (issue_reg),
        .rf_write_switch   (rf_write_switch),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .busy_mask         (busy_mask)
    );

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    logic [1:0] exp_rdy [4];

    initial begin
        reset       = 1'b1;
        req0_valid  = 1'b1;
        req0_reg    = 5'd1;
        req0_data   = 32'h11;
        req1_valid  = 1'b1;
        req1_reg    = 5'd2;
        req1_data   = 32'h22;
        issue_valid = 1'b0;
        issue_reg   = 5'd0;

        // reset: readies low, outputs cleared
        tick();
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        tick();
        check("rst_sw", rf_write_switch, 0);
        check("rst_reg", rf_write_register, 0);
        check("rst_data", rf_write_data, 0);
        check("rst_busy", busy_mask, 0);

        // contention from reset: req0, req1, req0, req1
        exp_rdy[0] = 2'b01;
        exp_rdy[1] = 2'b10;
        exp_rdy[2] = 2'b01;
        exp_rdy[3] = 2'b10;
        reset = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_rdy%0d", i),
                  {req1_ready, req0_ready}, exp_rdy[i]);
            tick();
            check($sformatf("cont_sw%0d", i), rf_write_switch, 1);
            check($sformatf("cont_reg%0d", i), rf_write_register,
                  exp_rdy[i][1] ? 5'd2 : 5'd1);
            check($sformatf("cont_dat%0d", i), rf_write_data,
                  exp_rdy[i][1] ? 32'h22 : 32'h11);
        end
        idle();
        tick();
        check("idle_sw", rf_write_switch, 0);
        check("idle_reg_hold", rf_write_register, 2);

        // single ALU request
        req0_valid = 1'b1;
        req0_reg   = 5'd5;
        req0_data  = 32'hDEADBEEF;
        settle();
        check("single_rdy0", req0_ready, 1);
        check("single_rdy1", req1_ready, 0);
        tick();
        idle();
        check("single_sw", rf_write_switch, 1);
        check("single_reg", rf_write_register, 5);
        check("single_dat", rf_write_data, 32'hDEADBEEF);
        tick();
        check("hold_sw", rf_write_switch, 0);
        check("hold_reg", rf_write_register, 5);
        check("hold_dat", rf_write_data, 32'hDEADBEEF);

        // scoreboard set by issue, cleared by load write
        issue_valid = 1'b1;
        issue_reg   = 5'd7;
        tick();
        idle();
        check("sb_set", busy_mask, 32'h00000080);
        req1_valid = 1'b1;
        req1_reg   = 5'd7;
        req1_data  = 32'h77;
        settle();
        check("sb_rdy1", req1_ready, 1);
        tick();
        idle();
        check("sb_clr", busy_mask, 0);
        check("sb_sw", rf_write_switch, 1);
        check("sb_reg", rf_write_register, 7);

        // set/clear collision on reg 3
        issue_valid = 1'b1;
        issue_reg   = 5'd3;
        tick();
        check("col_pre", busy_mask, 32'h00000008);
        req0_valid = 1'b1;
        req0_reg   = 5'd3;
        req0_data  = 32'h33;
        tick();
        idle();
        check("col_busy", busy_mask, 32'h00000008);
        check("col_sw", rf_write_switch, 1);
        check("col_reg", rf_write_register, 3);

        // register 0 is consumed but never written or tracked
        req0_valid  = 1'b1;
        req0_reg    = 5'd0;
        req0_data   = 32'h1234;
        issue_valid = 1'b1;
        issue_reg   = 5'd0;
        settle();
        check("r0_rdy0", req0_ready, 1);
        tick();
        idle();
        check("r0_sw", rf_write_switch, 0);
        check("r0_reg_hold", rf_write_register, 3);
        check("r0_dat_hold", rf_write_data, 32'h33);
        check("r0_busy", busy_mask, 32'h00000008);

        // handshake then reset: write dropped, pointer back to req0
        req0_valid = 1'b1;
        req0_reg   = 5'd9;
        req0_data  = 32'h99;
        settle();
        check("mid_rdy0", req0_ready, 1);
        tick();
        idle();
        reset = 1'b1;
        settle();
        check("mid_rst_rdy0", req0_ready, 0);
        tick();
        check("mid_sw", rf_write_switch, 0);
        check("mid_busy", busy_mask, 0);
        check("mid_reg", rf_write_register, 0);
        reset      = 1'b0;
        req0_valid = 1'b1;
        req0_reg   = 5'd1;
        req0_data  = 32'h11;
        req1_valid = 1'b1;
        req1_reg   = 5'd2;
        req1_data  = 32'h22;
        settle();
        check("post_rdy", {req1_ready, req0_ready}, 2'b01);
        tick();
        idle();
        check("post_reg", rf_write_register, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
